// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS-subset control unit: instruction decode, six-state sequencer,
// write-enable/datapath-select generation and a retired-instruction counter.
module mc_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  op,
  input  logic [5:0]  funct,
  input  logic        zero,
  output logic        PCWr,
  output logic        IRWr,
  output logic        RegWr,
  output logic        MemWr,
  output logic [1:0]  EOp,
  output logic [1:0]  ALUOp,
  output logic        ALUSrc,
  output logic        RegDst,
  output logic        MemtoReg,
  output logic [1:0]  NPCOp,
  output logic [2:0]  state,
  output logic [31:0] instr_cnt
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXE    = 3'd2,
    S_MEM_RD = 3'd3,
    S_MEM_WR = 3'd4,
    S_WB     = 3'd5
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic        pc_wr, ir_wr, reg_wr, mem_wr, retire;
  logic [1:0]  npc_op;

  logic is_addu, is_subu, is_ori, is_lui, is_lw, is_sw, is_beq, is_j, is_alu, legal;

  assign is_addu = (op == 6'b000000) && (funct == 6'b100001);
  assign is_subu = (op == 6'b000000) && (funct == 6'b100011);
  assign is_ori  = (op == 6'b001101);
  assign is_lui  = (op == 6'b001111);
  assign is_lw   = (op == 6'b100011);
  assign is_sw   = (op == 6'b101011);
  assign is_beq  = (op == 6'b000100);
  assign is_j    = (op == 6'b000010);
  assign is_alu  = is_addu | is_subu | is_ori | is_lui;
  assign legal   = is_alu | is_lw | is_sw | is_beq | is_j;

  // Datapath selects depend only on the instruction, never on the state.
  assign EOp      = is_ori ? 2'b01 : is_lui ? 2'b10 : is_beq ? 2'b11 : 2'b00;
  assign ALUSrc   = is_ori | is_lui | is_lw | is_sw;
  assign ALUOp    = (is_subu | is_beq) ? 2'b01 : is_ori ? 2'b10 : 2'b00;
  assign RegDst   = is_addu | is_subu;
  assign MemtoReg = is_lw;

  always_comb begin
    state_d = S_FETCH;
    pc_wr   = 1'b0;
    ir_wr   = 1'b0;
    reg_wr  = 1'b0;
    mem_wr  = 1'b0;
    retire  = 1'b0;
    npc_op  = 2'b00;
    case (state_q)
      S_FETCH: begin
        ir_wr   = 1'b1;
        pc_wr   = 1'b1;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        if (is_j) begin
          pc_wr  = 1'b1;
          npc_op = 2'b10;
          retire = 1'b1;
        end else if (legal) begin
          state_d = S_EXE;
        end
      end
      S_EXE: begin
        if (is_alu)     state_d = S_WB;
        else if (is_lw) state_d = S_MEM_RD;
        else if (is_sw) state_d = S_MEM_WR;
        else if (is_beq) begin
          pc_wr  = zero;
          npc_op = 2'b01;
          retire = 1'b1;
        end
      end
      S_MEM_RD: state_d = S_WB;
      S_MEM_WR: begin
        mem_wr = 1'b1;
        retire = 1'b1;
      end
      S_WB: begin
        reg_wr = 1'b1;
        retire = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
    cnt_d = cnt_q + 32'(retire);
  end

  // Reset masks every write enable immediately so an aborted instruction leaves no trace.
  assign PCWr      = pc_wr  & ~reset;
  assign IRWr      = ir_wr  & ~reset;
  assign RegWr     = reg_wr & ~reset;
  assign MemWr     = mem_wr & ~reset;
  assign NPCOp     = npc_op;
  assign state     = state_q;
  assign instr_cnt = cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      cnt_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
